fp_wb_queue: RTL and testbench

FP writeback queue: the write-side producer for the FP register file. It collects results from the pipelined FP unit (add/mul/fma) and the iterative FP unit (div/sqrt) and serialises them into a single write port. The port outputs `fp_reg_write`, `rd` and `wb_data`, and the register file captures them on the falling clock edge. For hazard control it also reports which source registers still have queued writes, and it can forward the youngest pending value.

---
 rtl/fp_wb_pkg.sv | 15 +
 rtl/fp_wb_match.sv | 34 +++
 rtl/fp_wb_queue.sv | 148 ++++++++++++++
 tb/tb_fp_wb_queue.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_wb_pkg.sv
// Shared FP package: register-index type, register count and the
// writeback queue entry layout used by the FP writeback path.
package fp_wb_pkg;

    localparam int FP_NUM_REGS = 32;
    localparam int FP_XLEN     = 32;

    typedef logic [$clog2(FP_NUM_REGS)-1:0] fp_reg_idx_t;

    typedef struct packed {
        fp_reg_idx_t        rd;
        logic [FP_XLEN-1:0] data;
    } fp_wb_entry_t;

endpackage

// File: rtl/fp_wb_match.sv
// Per-query youngest-match select over the writeback queue.
// Walks entries from oldest to youngest, so the last hit wins and the
// value reported is the one nearest the write pointer.
module fp_wb_match
    import fp_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  fp_reg_idx_t            rs,
    input  fp_reg_idx_t            rd_q   [DEPTH],
    input  logic [XLEN-1:0]        data_q [DEPTH],
    input  logic [DEPTH-1:0]       occ,
    input  logic [$clog2(DEPTH)-1:0] rd_ptr,
    output logic [XLEN-1:0]        fwd
);

    localparam int PTR_W = $clog2(DEPTH);

    // Priority select: younger occupied matches override older ones.
    always_comb begin
        logic [PTR_W-1:0] idx;
        // NOTE: every variable assigned in this block gets a default first, so no latch is inferred.
        fwd = '0;
        idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (occ[idx] && (rd_q[idx] == rs)) begin
                fwd = data_q[idx];
            end
        end
    end

endmodule

// File: rtl/fp_wb_queue.sv
// FP writeback queue: arbitrates the pipelined (A) and iterative (B) FP
// units into one regfile write port and answers hazard queries.
// Optional macro FP_WB_FORWARD_EN builds the forwarding data path for
// fwd1..3; without it those outputs are tied to 0 and only pendN exists.
module fp_wb_queue
    import fp_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  fp_reg_idx_t            a_rd,
    input  logic [XLEN-1:0]        a_data,
    input  logic                   b_valid,
    output logic                   b_ready,
    input  fp_reg_idx_t            b_rd,
    input  logic [XLEN-1:0]        b_data,
    input  logic                   write_enable,
    input  logic                   flush,
    output logic                   fp_reg_write,
    output fp_reg_idx_t            rd,
    output logic [XLEN-1:0]        wb_data,
    input  fp_reg_idx_t            rs1,
    input  fp_reg_idx_t            rs2,
    input  fp_reg_idx_t            rs3,
    output logic                   pend1,
    output logic                   pend2,
    output logic                   pend3,
    output logic [XLEN-1:0]        fwd1,
    output logic [XLEN-1:0]        fwd2,
    output logic [XLEN-1:0]        fwd3,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fp_reg_idx_t      rd_q   [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             grant_b;   // 0: A wins a tie, 1: B wins a tie
    logic             full;
    logic             empty;
    logic             push_a;
    logic             push_b;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] occ;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Arbitration: a lone producer only sees full; on a tie the grant bit picks.
    always_comb begin
        a_ready = reset && !flush && !full && (!b_valid || !grant_b);
        b_ready = reset && !flush && !full && (!a_valid ||  grant_b);
    end

    assign push_a = a_valid && a_ready;
    assign push_b = b_valid && b_ready;
    assign push   = push_a || push_b;

    // Drain port: head is presented whenever present, written only when enabled.
    always_comb begin
        fp_reg_write = !empty && write_enable && !flush;
        rd           = empty ? '0 : rd_q[rd_ptr];
        wb_data      = empty ? '0 : data_q[rd_ptr];
    end

    assign pop = fp_reg_write;

    // Pointers, occupancy and round-robin grant.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            grant_b <= 1'b0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && a_valid && b_valid) grant_b <= !grant_b;
        end
    end

    // Entry storage: written at the write pointer on an accepted push.
    always_ff @(posedge clock) begin
        // NOTE: storage is deliberately not reset; occupancy alone decides which entries are live.
        if (push) begin
            rd_q[wr_ptr]   <= push_a ? a_rd   : b_rd;
            data_q[wr_ptr] <= push_a ? a_data : b_data;
        end
    end

    // Occupancy mask: the count entries starting at the read pointer are live.
    always_comb begin
        logic [PTR_W-1:0] idx;
        occ = '0;
        idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx      = rd_ptr + PTR_W'(k);
            occ[idx] = (CNT_W'(k) < count);
        end
    end

    // Pending flags: any live entry targeting the queried register.
    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        pend3 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            pend1 = pend1 || (occ[i] && (rd_q[i] == rs1));
            pend2 = pend2 || (occ[i] && (rd_q[i] == rs2));
            pend3 = pend3 || (occ[i] && (rd_q[i] == rs3));
        end
    end

`ifdef FP_WB_FORWARD_EN
    fp_wb_match #(.DEPTH(DEPTH), .XLEN(XLEN)) u_match1 (
        .rs(rs1), .rd_q(rd_q), .data_q(data_q), .occ(occ), .rd_ptr(rd_ptr), .fwd(fwd1)
    );
    fp_wb_match #(.DEPTH(DEPTH), .XLEN(XLEN)) u_match2 (
        .rs(rs2), .rd_q(rd_q), .data_q(data_q), .occ(occ), .rd_ptr(rd_ptr), .fwd(fwd2)
    );
    fp_wb_match #(.DEPTH(DEPTH), .XLEN(XLEN)) u_match3 (
        .rs(rs3), .rd_q(rd_q), .data_q(data_q), .occ(occ), .rd_ptr(rd_ptr), .fwd(fwd3)
    );
`else
    assign fwd1 = '0;
    assign fwd2 = '0;
    assign fwd3 = '0;
`endif

endmodule

// File: tb/tb_fp_wb_queue.sv
// Self-checking bench for fp_wb_queue: a scoreboard queue models the FIFO,
// the round-robin grant and the hazard query; the DUT is compared against
// it at every falling edge.
module tb_fp_wb_queue;
    import fp_wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic              clock;
    logic              reset;
    logic              a_valid, a_ready, b_valid, b_ready;
    fp_reg_idx_t       a_rd, b_rd, rd, rs1, rs2, rs3;
    logic [XLEN-1:0]   a_data, b_data, wb_data, fwd1, fwd2, fwd3;
    logic              write_enable, flush, fp_reg_write;
    logic              pend1, pend2, pend3;
    logic [$clog2(DEPTH):0] count;

    fp_wb_entry_t sb[$];
    logic         m_grant_b;
    logic         last_acc_a, last_acc_b;
    int           n_checks;
    int           n_fail;

    fp_wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .write_enable(write_enable), .flush(flush),
        .fp_reg_write(fp_reg_write), .rd(rd), .wb_data(wb_data),
        .rs1(rs1), .rs2(rs2), .rs3(rs3),
        .pend1(pend1), .pend2(pend2), .pend3(pend3),
        .fwd1(fwd1), .fwd2(fwd2), .fwd3(fwd3),
        .count(count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic exp_query(input fp_reg_idx_t rs, output logic p, output logic [XLEN-1:0] f);
        p = 1'b0;
        f = '0;
        foreach (sb[i]) begin
            if (sb[i].rd == rs) begin
                p = 1'b1;
                f = sb[i].data;
            end
        end
`ifndef FP_WB_FORWARD_EN
        f = '0;
`endif
    endtask

    // One clock cycle: compare at the falling edge, advance the model, wait past the rising edge.
    task automatic step();
        logic            exp_wr, ea, eb, acc_a, acc_b, p, full_m;
        logic [XLEN-1:0] f;
        fp_wb_entry_t    h, e;
        @(negedge clock);
        exp_wr = (sb.size() != 0) && write_enable && !flush;
        check("fp_reg_write", fp_reg_write, exp_wr);
        check("count", count, sb.size());
        h = (sb.size() != 0) ? sb[0] : '0;
        check("rd", rd, h.rd);
        check("wb_data", wb_data, h.data);
        exp_query(rs1, p, f); check("pend1", pend1, p); check("fwd1", fwd1, f);
        exp_query(rs2, p, f); check("pend2", pend2, p); check("fwd2", fwd2, f);
        exp_query(rs3, p, f); check("pend3", pend3, p); check("fwd3", fwd3, f);
        full_m = (sb.size() >= DEPTH);
        ea = !flush && !full_m && (!b_valid || !m_grant_b);
        eb = !flush && !full_m && (!a_valid ||  m_grant_b);
        if (a_valid) check("a_ready", a_ready, ea);
        if (b_valid) check("b_ready", b_ready, eb);
        acc_a = a_valid && ea;
        acc_b = b_valid && eb;
        if (flush) begin
            sb.delete();
        end else begin
            if (exp_wr) void'(sb.pop_front());
            if (acc_a) begin e.rd = a_rd; e.data = a_data; sb.push_back(e); end
            if (acc_b) begin e.rd = b_rd; e.data = b_data; sb.push_back(e); end
            if ((acc_a || acc_b) && a_valid && b_valid) m_grant_b = !m_grant_b;
        end
        last_acc_a = acc_a;
        last_acc_b = acc_b;
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        m_grant_b = 1'b0; last_acc_a = 1'b0; last_acc_b = 1'b0;
        reset = 1'b0; flush = 1'b0; write_enable = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1;
        a_rd = '0; b_rd = '0; a_data = '0; b_data = '0;
        rs1 = 5'd3; rs2 = 5'd7; rs3 = 5'd0;

        // Reset held: everything quiet, producers refused.
        repeat (2) @(posedge clock);
        #1;
        check("rst_count", count, 0);
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_wr", fp_reg_write, 0);
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;

        // Single write with 1-cycle latency to the port.
        write_enable = 1'b1;
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h3F80_0000;
        step();
        a_valid = 1'b0;
        step();
        step();
        check("single_drained", count, 0);

        // Both producers every cycle, no drain: alternating grant, fills to DEPTH.
        write_enable = 1'b0;
        a_valid = 1'b1; a_rd = 5'd1; a_data = 32'hA000_0001;
        b_valid = 1'b1; b_rd = 5'd9; b_data = 32'hB000_0001;
        for (int i = 0; i < 6; i++) begin
            step();
            if (last_acc_a) begin a_rd = a_rd + 5'd1; a_data = a_data + 1; end
            if (last_acc_b) begin b_rd = b_rd + 5'd1; b_data = b_data + 1; end
        end
        check("full_count", count, DEPTH);
        check("full_a_ready", a_ready, 0);
        check("full_b_ready", b_ready, 0);

        // Drain the full queue while A keeps offering.
        b_valid = 1'b0;
        write_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (last_acc_a) begin a_rd = a_rd + 5'd1; a_data = a_data + 1; end
        end
        a_valid = 1'b0;
        repeat (5) step();

        // Two queued writes to f7: youngest forwarded.
        write_enable = 1'b0;
        rs1 = 5'd7; rs2 = 5'd3; rs3 = 5'd7;
        a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h4000_0000;
        step();
        a_data = 32'h4040_0000;
        step();
        a_valid = 1'b0;
        step();
        check("f7_pend1", pend1, 1);
`ifdef FP_WB_FORWARD_EN
        check("f7_fwd1", fwd1, 32'h4040_0000);
`else
        check("f7_fwd1", fwd1, 0);
`endif

        // Flush with three entries while A is offering.
        a_valid = 1'b1; a_rd = 5'd0; a_data = 32'h1111_1111;
        step();
        a_valid = 1'b1;
        write_enable = 1'b1;
        flush = 1'b1;
        a_rd = 5'd2; a_data = 32'h2222_2222;
        step();
        flush = 1'b0;
        a_valid = 1'b0;
        step();
        check("flush_count", count, 0);

        // Asynchronous reset mid-cycle with two entries.
        write_enable = 1'b0;
        a_valid = 1'b1; a_rd = 5'd4; a_data = 32'h4444_0000;
        step();
        a_data = 32'h4444_0001;
        step();
        write_enable = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        #1;
        check("pre_rst_wr", fp_reg_write, 1);
        check("pre_rst_count", count, 2);
        #1 reset = 1'b0;
        #1;
        check("async_count", count, 0);
        check("async_wr", fp_reg_write, 0);
        check("async_a_ready", a_ready, 0);
        check("async_b_ready", b_ready, 0);
        sb.delete();
        m_grant_b = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;

        // Random traffic: producers hold their offer until accepted.
        last_acc_a = 1'b0; last_acc_b = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (last_acc_a || !a_valid) begin
                a_valid = 1'($urandom_range(0, 1));
                a_rd    = 5'($urandom_range(0, 7));
                a_data  = $urandom;
            end
            if (last_acc_b || !b_valid) begin
                b_valid = 1'($urandom_range(0, 1));
                b_rd    = 5'($urandom_range(0, 7));
                b_data  = $urandom;
            end
            write_enable = ($urandom_range(0, 3) != 0);
            flush        = ($urandom_range(0, 31) == 0);
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            rs3 = 5'($urandom_range(0, 7));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
